// File: rtl/led_pattern_gen_if.sv
// LED pattern generator bus: raw key in, LED drive and current mode out.
// The generator takes the slave view; whatever presses the key and watches
// the LEDs takes the master view.
interface led_pattern_gen_if #(
   parameter int LEDS_NR = 6
);
   logic               key;
   logic [LEDS_NR-1:0] led;
   logic [1:0]         mode;

   modport master (
      output key,
      input  led,
      input  mode
   );

   modport slave (
      input  key,
      output led,
      output mode
   );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator.
// A button steps through four display modes (COUNT, WALK, BOUNCE, HOLD); a
// free-running prescaler sets the speed at which the pattern advances.
// Optional build macro KEY_DEBOUNCE_EN: when defined, the synchronized key must
// hold a new level for 2^DEBOUNCE_W cycles before it is accepted; when left
// undefined, the synchronized key is accepted one cycle later with no filtering.
module led_pattern_gen #(
   parameter int LEDS_NR        = 6,
   parameter int PRESCALE_W     = 22,
   parameter int DEBOUNCE_W     = 16,
   parameter bit LED_ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   led_pattern_gen_if.slave bus
);

   typedef enum logic [1:0] {
      MODE_COUNT  = 2'd0,
      MODE_WALK   = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_HOLD   = 2'd3
   } modeT;

   localparam logic [LEDS_NR-1:0] PAT_ONE = LEDS_NR'(1);

   // Refuse to elaborate with a channel count or counter width that makes no sense.
   generate
      if (LEDS_NR < 1 || LEDS_NR > 32 || PRESCALE_W < 1 || DEBOUNCE_W < 1) begin : g_badParams
         $error("led_pattern_gen: LEDS_NR must be 1..32 and counter widths at least 1");
      end
   endgenerate

   logic                  r_keySync1;
   logic                  r_keySync2;
   logic                  r_keyDb;
   logic                  r_keyDbPrev;
   logic [1:0]            r_settle;
   logic                  r_armed;
   logic [PRESCALE_W-1:0] r_prescale;
   modeT                  r_mode;
   logic [LEDS_NR-1:0]    r_pat;
   logic                  r_dirLeft;

   logic                  w_press;
   logic                  w_tick;
   modeT                  w_modeNext;
   logic [LEDS_NR-1:0]    w_patNext;
   logic                  w_dirLeftNext;

   // Two-flop synchronizer: the raw button is asynchronous, so nothing else
   // may look at it before it has passed through both flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_keySync1 <= 1'b0;
         r_keySync2 <= 1'b0;
      end else begin
         r_keySync1 <= bus.key;
         r_keySync2 <= r_keySync1;
      end
   end

`ifdef KEY_DEBOUNCE_EN
   logic [DEBOUNCE_W-1:0] r_dbCnt;

   // Debounce: count how long the synchronized key has disagreed with the
   // accepted level; only a disagreement lasting 2^DEBOUNCE_W cycles is
   // accepted, and any return to agreement restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_keyDb <= 1'b0;
         r_dbCnt <= '0;
      end else if (r_keySync2 == r_keyDb) begin
         r_dbCnt <= '0;
      end else if (&r_dbCnt) begin
         r_keyDb <= r_keySync2;
         r_dbCnt <= '0;
      end else begin
         r_dbCnt <= r_dbCnt + DEBOUNCE_W'(1);
      end
   end
`else
   // Without debouncing the accepted level simply follows the synchronizer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_keyDb <= 1'b0;
      end else begin
         r_keyDb <= r_keySync2;
      end
   end
`endif

   // Press detection bookkeeping. The previous accepted level gives the rising
   // edge. The armed flag keeps a key that was held down through reset from
   // counting as a press: it only becomes set once the synchronizer has
   // refilled after reset (two cycles) and shows the key released.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_keyDbPrev <= 1'b0;
         r_settle    <= 2'b00;
         r_armed     <= 1'b0;
      end else begin
         r_keyDbPrev <= r_keyDb;
         r_settle    <= {r_settle[0], 1'b1};
         if (r_settle[1] && !r_keySync2) begin
            r_armed <= 1'b1;
         end
      end
   end

   assign w_press = r_keyDb & ~r_keyDbPrev & r_armed;

   // Free-running prescaler; it keeps counting in every mode, including HOLD,
   // and the step tick is the cycle in which it reads all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prescale <= '0;
      end else begin
         r_prescale <= r_prescale + PRESCALE_W'(1);
      end
   end

   assign w_tick = &r_prescale;

   // Mode state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mode <= MODE_COUNT;
      end else begin
         r_mode <= w_modeNext;
      end
   end

   // Next mode: each press steps to the following mode, HOLD wrapping to COUNT.
   always_comb begin
      w_modeNext = r_mode;
      if (w_press) begin
         w_modeNext = modeT'(r_mode + 2'd1);
      end
   end

   // Pattern and direction for the next cycle. A press takes priority over a
   // coincident tick: the entry value of the new mode is loaded and that tick
   // is dropped. Bouncing turns around in the same step that leaves an end
   // bit, so each end is lit for exactly one tick.
   always_comb begin
      w_patNext     = r_pat;
      w_dirLeftNext = r_dirLeft;
      if (w_press) begin
         case (w_modeNext)
            MODE_COUNT: begin
               w_patNext = '0;
            end
            MODE_WALK, MODE_BOUNCE: begin
               w_patNext     = PAT_ONE;
               w_dirLeftNext = 1'b1;
            end
            default: begin
               w_patNext = r_pat;
            end
         endcase
      end else if (w_tick) begin
         case (r_mode)
            MODE_COUNT: begin
               w_patNext = r_pat + PAT_ONE;
            end
            MODE_WALK: begin
               w_patNext = (r_pat << 1) | (r_pat >> (LEDS_NR - 1));
            end
            MODE_BOUNCE: begin
               if (LEDS_NR == 1) begin
                  w_patNext = PAT_ONE;
               end else if (r_dirLeft) begin
                  if (r_pat[LEDS_NR-1]) begin
                     w_patNext     = r_pat >> 1;
                     w_dirLeftNext = 1'b0;
                  end else begin
                     w_patNext = r_pat << 1;
                  end
               end else begin
                  if (r_pat[0]) begin
                     w_patNext     = r_pat << 1;
                     w_dirLeftNext = 1'b1;
                  end else begin
                     w_patNext = r_pat >> 1;
                  end
               end
            end
            default: begin
               w_patNext = r_pat;
            end
         endcase
      end
   end

   // Pattern and direction registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pat     <= '0;
         r_dirLeft <= 1'b1;
      end else begin
         r_pat     <= w_patNext;
         r_dirLeft <= w_dirLeftNext;
      end
   end

   assign bus.led  = r_pat ^ {LEDS_NR{LED_ACTIVE_LOW}};
   assign bus.mode = r_mode;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen (4 LEDs, 8-cycle tick, 4-cycle debounce,
// active-low LEDs). A behavioural model tracks mode and pattern from the
// key/reset stimulus and every scenario compares the DUT against it and
// against the documented pattern sequences.
module tb_led_pattern_gen;

   localparam int N  = 4;
   localparam int PW = 3;
   localparam int DW = 2;
`ifdef KEY_DEBOUNCE_EN
   localparam bit DEBOUNCE_ON = 1'b1;
`else
   localparam bit DEBOUNCE_ON = 1'b0;
`endif
   // Edges from the first edge that samples the key high to the edge where
   // the mode changes: two synchronizer stages, the accepted-level register
   // (plus the debounce dwell), then the press itself.
   localparam int PRESS_LAT = DEBOUNCE_ON ? 3 + (1 << DW) - 1 : 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int nChecks = 0;
   int nFails  = 0;

   led_pattern_gen_if #(.LEDS_NR(N)) busIf ();

   led_pattern_gen #(
      .LEDS_NR       (N),
      .PRESCALE_W    (PW),
      .DEBOUNCE_W    (DW),
      .LED_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(busIf.slave)
   );

   always #5 clk = ~clk;

   // Reference model state
   bit keyPipe[$];
   bit mDb;
   bit mDbPrev;
   bit mArmed;
   int mRun;
   int mCyc;
   int mMode;
   int mPat;
   int mPos;
   bit mLeft;

   function automatic logic [3:0] modelLed();
      logic [3:0] p;
      p = mPat[3:0];
      return ~p;
   endfunction

   function automatic logic [1:0] modelMode();
      return mMode[1:0];
   endfunction

   // Advance the model by one clock edge given the key and reset seen at it.
   task automatic modelStep(input bit k, input bit r);
      bit keyS;
      bit tick;
      bit press;
      if (r) begin
         keyPipe = '{1'b0, 1'b0};
         mDb = 0; mDbPrev = 0; mArmed = 0; mRun = 0; mCyc = 0;
         mMode = 0; mPat = 0; mPos = 0; mLeft = 1;
         return;
      end
      keyS  = keyPipe[0];
      tick  = (mCyc % (1 << PW)) == (1 << PW) - 1;
      press = mDb && !mDbPrev && mArmed;
      if (press) begin
         mMode = (mMode + 1) % 4;
         if (mMode == 0) begin
            mPat = 0;
         end else if (mMode == 1 || mMode == 2) begin
            mPos = 0; mLeft = 1; mPat = 1;
         end
      end else if (tick) begin
         case (mMode)
            0: mPat = (mPat + 1) % (1 << N);
            1: begin mPos = (mPos + 1) % N; mPat = 1 << mPos; end
            2: begin
               if (mLeft) begin
                  if (mPos == N - 1) begin mLeft = 0; mPos = mPos - 1; end
                  else mPos = mPos + 1;
               end else begin
                  if (mPos == 0) begin mLeft = 1; mPos = mPos + 1; end
                  else mPos = mPos - 1;
               end
               mPat = 1 << mPos;
            end
            default: ;
         endcase
      end
      mDbPrev = mDb;
      if (DEBOUNCE_ON) begin
         if (keyS != mDb) begin
            mRun++;
            if (mRun == (1 << DW)) begin mDb = keyS; mRun = 0; end
         end else begin
            mRun = 0;
         end
      end else begin
         mDb = keyS;
      end
      if (mCyc >= 2 && !keyS) mArmed = 1;
      void'(keyPipe.pop_front());
      keyPipe.push_back(k);
      mCyc++;
   endtask

   // Drive key/reset away from the edge, clock once, update the model, and
   // leave the bench 1 time unit after the edge for sampling.
   task automatic applyStimulus(input bit k, input bit r);
      @(negedge clk);
      busIf.key = k;
      rst       = r;
      @(posedge clk);
      modelStep(k, r);
      #1;
   endtask

   // Stimulus-only press: key high long enough to be accepted, then released.
   task automatic pressKey();
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
      nChecks++;
      if (busIf.led !== 4'b1111) begin
         nFails++;
         $display("[TB] FAIL reset_led: got %b, expected 1111", busIf.led);
      end
      nChecks++;
      if (busIf.mode !== 2'd0) begin
         nFails++;
         $display("[TB] FAIL reset_mode: got %0d, expected 0", busIf.mode);
      end
   endtask

   task automatic test_count();
      logic [3:0] want;
      for (int t = 1; t <= 17; t++) begin
         for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 1'b0);
            nChecks++;
            if (busIf.led !== modelLed() || busIf.mode !== modelMode()) begin
               nFails++;
               $display("[TB] FAIL count_model @%0t: led=%b mode=%0d, expected led=%b mode=%0d",
                        $time, busIf.led, busIf.mode, modelLed(), modelMode());
            end
         end
         want = 4'(t % 16);
         want = ~want;
         nChecks++;
         if (busIf.led !== want || busIf.mode !== 2'd0) begin
            nFails++;
            $display("[TB] FAIL count_tick%0d: led=%b mode=%0d, expected led=%b mode=0",
                     t, busIf.led, busIf.mode, want);
         end
      end
   endtask

   // Press into the given mode and record the patterns shown there in order.
   task automatic test_sequence(input string name, input int wantMode, input int budget,
                                input int expSeq[$]);
      int seen[$];
      int prev;
      int p;
      logic [3:0] inv;
      prev = -1;
      for (int i = 0; i < budget && seen.size() < expSeq.size(); i++) begin
         applyStimulus(i < 10, 1'b0);
         nChecks++;
         if (busIf.led !== modelLed() || busIf.mode !== modelMode()) begin
            nFails++;
            $display("[TB] FAIL %s_model @%0t: led=%b mode=%0d, expected led=%b mode=%0d",
                     name, $time, busIf.led, busIf.mode, modelLed(), modelMode());
         end
         if (busIf.mode === 2'(wantMode)) begin
            inv = ~busIf.led;
            p   = int'(inv);
            if (p != prev) begin
               seen.push_back(p);
               prev = p;
            end
         end
      end
      nChecks++;
      if (seen.size() != expSeq.size()) begin
         nFails++;
         $display("[TB] FAIL %s_timeout: saw %0d patterns, expected %0d", name, seen.size(), expSeq.size());
      end else begin
         for (int i = 0; i < expSeq.size(); i++) begin
            nChecks++;
            if (seen[i] != expSeq[i]) begin
               nFails++;
               $display("[TB] FAIL %s_pat%0d: got %b, expected %b", name, i, 4'(seen[i]), 4'(expSeq[i]));
            end
         end
      end
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
   endtask

   task automatic test_short_press();
      int startMode;
      logic [1:0] want;
      startMode = mMode;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b0);
         nChecks++;
         if (busIf.led !== modelLed() || busIf.mode !== modelMode()) begin
            nFails++;
            $display("[TB] FAIL short_model @%0t: led=%b mode=%0d, expected led=%b mode=%0d",
                     $time, busIf.led, busIf.mode, modelLed(), modelMode());
         end
      end
      want = 2'((startMode + (DEBOUNCE_ON ? 0 : 1)) % 4);
      nChecks++;
      if (busIf.mode !== want) begin
         nFails++;
         $display("[TB] FAIL short_press_mode: got %0d, expected %0d", busIf.mode, want);
      end
   endtask

   task automatic test_press_tick();
      int target;
      logic [3:0] held;
      target = (7 - PRESS_LAT + 8) % 8;
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      while (!(mCyc >= 8 && mCyc % 8 == target)) applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
      nChecks++;
      if (busIf.led !== 4'b1110 || busIf.mode !== 2'd1) begin
         nFails++;
         $display("[TB] FAIL press_tick: led=%b mode=%0d, expected led=1110 mode=1", busIf.led, busIf.mode);
      end
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
      pressKey();
      pressKey();
      nChecks++;
      if (busIf.mode !== 2'd3 || busIf.led !== modelLed()) begin
         nFails++;
         $display("[TB] FAIL hold_entry: led=%b mode=%0d, expected led=%b mode=3", busIf.led, busIf.mode, modelLed());
      end
      held = busIf.led;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b0, 1'b0);
         nChecks++;
         if (busIf.led !== held || busIf.mode !== 2'd3) begin
            nFails++;
            $display("[TB] FAIL hold_frozen @%0t: led=%b mode=%0d, expected led=%b mode=3",
                     $time, busIf.led, busIf.mode, held);
         end
      end
   endtask

   task automatic test_reset_held();
      pressKey();
      pressKey();
      nChecks++;
      if (busIf.mode !== 2'd1) begin
         nFails++;
         $display("[TB] FAIL held_walk_entry: mode=%0d, expected 1", busIf.mode);
      end
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);
      nChecks++;
      if (busIf.led !== 4'b1111 || busIf.mode !== 2'd0) begin
         nFails++;
         $display("[TB] FAIL held_reset: led=%b mode=%0d, expected led=1111 mode=0", busIf.led, busIf.mode);
      end
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b0);
         nChecks++;
         if (busIf.mode !== 2'd0 || busIf.led !== modelLed()) begin
            nFails++;
            $display("[TB] FAIL held_no_press @%0t: led=%b mode=%0d, expected led=%b mode=0",
                     $time, busIf.led, busIf.mode, modelLed());
         end
      end
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
      pressKey();
      nChecks++;
      if (busIf.mode !== 2'd1) begin
         nFails++;
         $display("[TB] FAIL held_repress: mode=%0d, expected 1", busIf.mode);
      end
   endtask

   task automatic test_random();
      bit level;
      bit r;
      int len;
      int cyc;
      cyc = 0;
      while (cyc < 500) begin
         level = 1'($urandom_range(0, 1));
         len   = $urandom_range(1, 12);
         for (int i = 0; i < len; i++) begin
            r = ($urandom_range(0, 99) < 2);
            applyStimulus(level, r);
            cyc++;
            nChecks++;
            if (busIf.led !== modelLed() || busIf.mode !== modelMode()) begin
               nFails++;
               $display("[TB] FAIL random_model @%0t: led=%b mode=%0d, expected led=%b mode=%0d",
                        $time, busIf.led, busIf.mode, modelLed(), modelMode());
            end
         end
      end
   endtask

   initial begin
      busIf.key = 1'b0;
      test_reset();
      test_count();
      test_sequence("walk", 1, 80, '{1, 2, 4, 8, 1});
      test_sequence("bounce", 2, 120, '{1, 2, 4, 8, 4, 2, 1, 2});
      test_short_press();
      test_press_tick();
      test_reset_held();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter LEDS_NR, default 6: LED channel count; legal range 1..32.
REQ-002 Parameter PRESCALE_W, default 22: prescaler width; one step tick every 2^PRESCALE_W clk cycles.
REQ-003 Parameter DEBOUNCE_W, default 16: debounce counter width.
REQ-004 Parameter LED_ACTIVE_LOW, default 1: when 1, the led output is inverted.
REQ-005 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port key, input, 1: raw, asynchronous button input, active-high when pressed.
REQ-008 Port led, output, LEDS_NR: LED drive, registered pattern after polarity inversion.
REQ-009 Port mode, output, 2: current mode (0 COUNT, 1 WALK, 2 BOUNCE, 3 HOLD).

Function
REQ-010 key SHALL pass through a 2-flop synchronizer (key_s) before any other use.
REQ-011 Debounced level key_db SHALL take its source per REQ-032/REQ-033.
REQ-012 press SHALL be a 1-cycle internal pulse on each key_db 0->1 transition; releases produce no event.
REQ-013 The prescaler SHALL free-run (all modes, including HOLD); tick SHALL be a 1-cycle pulse when the prescaler is all-ones, after which it wraps to 0.
REQ-014 On press, mode SHALL advance 0->1->2->3->0 at the next clock edge.
REQ-015 On entry to COUNT, pat SHALL load 0; on entry to WALK or BOUNCE, pat SHALL load one-hot bit0 and dir SHALL be set to left; on entry to HOLD, pat SHALL be retained.
REQ-016 COUNT: on tick, pat <= pat+1, modulo 2^LEDS_NR, with silent wrap.
REQ-017 WALK: on tick, pat SHALL rotate left by 1; MSB wraps to bit0.
REQ-018 BOUNCE: on tick, pat SHALL shift toward dir; at bit LEDS_NR-1 dir flips to right, at bit0 dir flips to left.
REQ-019 BOUNCE: endpoints SHALL be lit exactly one tick each (no double dwell).
REQ-020 When LEDS_NR=1, WALK and BOUNCE SHALL hold pat=1.
REQ-021 HOLD: pat SHALL remain frozen regardless of tick.
REQ-022 If press and tick coincide, press SHALL win: the entry load of REQ-015 applies and the tick is discarded.
REQ-023 led SHALL equal pat XOR {LEDS_NR{LED_ACTIVE_LOW}}; pat is registered, and led SHALL change on the edge after tick/press with no added latency.
REQ-024 mode SHALL be driven directly from the mode register.

Reset
REQ-025 rst SHALL take precedence over press and tick in the same cycle.
REQ-026 On reset: mode=0, pat=0, dir=left, prescaler=0, synchronizer flops=0, key_db=0, debounce counter=0, press/tick=0.
REQ-027 Out of reset, led SHALL equal all-ones when LED_ACTIVE_LOW=1 and all-zeros otherwise.
REQ-028 Out of reset, mode SHALL equal 0.
REQ-029 Reset asserted mid-operation SHALL return all state to REQ-026 values at that edge, discarding any in-progress debounce.
REQ-030 A key held through reset SHALL NOT generate a press until key_db rises after reset deasserts.

Configuration
REQ-031 The macro KEY_DEBOUNCE_EN SHALL select the key_db source.
REQ-032 With KEY_DEBOUNCE_EN defined: a DEBOUNCE_W counter clears while key_s==key_db and increments while they differ; when it is all-ones and they still differ, key_db <= key_s and the counter clears. A level must therefore be stable 2^DEBOUNCE_W cycles.
REQ-033 Without KEY_DEBOUNCE_EN: key_db <= key_s each cycle; the debounce counter and DEBOUNCE_W SHALL be unused.

Verification (LEDS_NR=4, PRESCALE_W=3, DEBOUNCE_W=2, LED_ACTIVE_LOW=1)
REQ-034 Release reset, key=0, 17 ticks -> pat 0,1,2..15,0,1 (led=~pat, e.g. 4'b1110 after tick 1); mode stays 0.
REQ-035 key high 10 cycles, debounce on -> mode=1, pat=0001, then ticks give 0010,0100,1000,0001.
REQ-036 Second press -> mode=2, pat sequence 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-037 key high 3 cycles then low -> with KEY_DEBOUNCE_EN: no mode change; without it: mode advances by exactly one.
REQ-038 Press pulse aligned with tick in COUNT->WALK -> pat=0001 (not 0010); third press into HOLD -> pat frozen for at least 4 ticks.
REQ-039 rst pulsed mid-WALK with key held high -> next edge led=1111, mode=0; no press until key released and re-pressed.
